jacobi_pivot_select: RTL and testbench

- Upstream stage of the Jacobi rotation step in the covariance eigen-decomposition path.
- Accepts an N_STOCKS x N_STOCKS symmetric fixed-point matrix and scans the strict upper triangle for the off-diagonal element with the largest magnitude.
- Emits pivot indices (i, j) together with a registered snapshot of the matrix, in the format the rotation stage consumes.
- Flags convergence when the largest magnitude is at or below a threshold, or when the rotation budget for the current problem is exhausted.

---
 rtl/jacobi_pivot_select.sv | 156 +++++++++++++++
 tb/tb_jacobi_pivot_select.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/jacobi_pivot_select.sv
// Jacobi pivot selection: scans the strict upper triangle of a symmetric
// matrix, one pair per cycle, for the largest-magnitude off-diagonal element.
// The result (i, j, |a_ij|), convergence flags and the matrix snapshot are
// held at the output until the rotation stage takes them.
module jacobi_pivot_select #(
  parameter int WIDTH    = 16,
  parameter int N_STOCKS = 4,
  parameter int MAX_ITER = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                axiiv,
  input  logic                                first,
  output logic                                ready_out,
  input  logic [N_STOCKS*N_STOCKS*WIDTH-1:0]  mat_in,
  input  logic [WIDTH-1:0]                    threshold,
  input  logic                                ready_in,
  output logic                                axiov,
  output logic [$clog2(WIDTH)-1:0]            i,
  output logic [$clog2(WIDTH)-1:0]            j,
  output logic [WIDTH-1:0]                    max_abs,
  output logic                                converged,
  output logic                                limit_hit,
  output logic [N_STOCKS*N_STOCKS*WIDTH-1:0]  mat_out
);

  localparam int IW = $clog2(WIDTH);
  localparam int PW = (N_STOCKS > 2) ? $clog2(N_STOCKS) : 1;
  localparam int CW = $clog2(MAX_ITER + 1);

  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

  state_t state_q, state_d;

  // Same bit layout as mat_in: element [r][c] sits at bits (r*N+c)*WIDTH.
  logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] mat_q;
  logic [WIDTH-1:0] thr_q;
  logic [WIDTH-1:0] best_q;
  logic [PW-1:0]    bi_q, bj_q;
  logic [PW-1:0]    r_q, c_q;
  logic [CW-1:0]    cnt_q;
  logic             axiov_q, conv_q, lim_q;
  logic [IW-1:0]    i_q, j_q;
  logic [WIDTH-1:0] max_q;

  logic [WIDTH-1:0] elem, mag, nbest;
  logic [PW-1:0]    nbi, nbj;
  logic             last_pair, lim_now;

  // Magnitude of the current pair, with -2^(W-1) clamped to 2^(W-1)-1, and
  // the running best after folding it in (strictly-greater keeps ties early).
  always_comb begin
    elem = mat_q[r_q][c_q];
    if (elem == {1'b1, {(WIDTH-1){1'b0}}})
      mag = {1'b0, {(WIDTH-1){1'b1}}};
    else if (elem[WIDTH-1])
      mag = -elem;
    else
      mag = elem;
    nbest = best_q;
    nbi   = bi_q;
    nbj   = bj_q;
    if (mag > best_q) begin
      nbest = mag;
      nbi   = r_q;
      nbj   = c_q;
    end
    last_pair = (r_q == PW'(N_STOCKS - 2)) && (c_q == PW'(N_STOCKS - 1));
    lim_now   = (cnt_q == CW'(MAX_ITER));
  end

  // Next-state logic for the IDLE -> SCAN -> OUT loop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (axiiv) state_d = SCAN;
      SCAN:    if (last_pair) state_d = OUT;
      OUT:     if (ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: capture at acceptance, scan pointer/best tracking, output regs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat_q   <= '0;
      thr_q   <= '0;
      best_q  <= '0;
      bi_q    <= '0;
      bj_q    <= PW'(1);
      r_q     <= '0;
      c_q     <= PW'(1);
      cnt_q   <= '0;
      axiov_q <= 1'b0;
      conv_q  <= 1'b0;
      lim_q   <= 1'b0;
      i_q     <= '0;
      j_q     <= IW'(1);
      max_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (axiiv) begin
          mat_q  <= mat_in;
          thr_q  <= threshold;
          best_q <= '0;
          bi_q   <= '0;
          bj_q   <= PW'(1);
          r_q    <= '0;
          c_q    <= PW'(1);
          if (first) cnt_q <= '0;
        end
        SCAN: begin
          best_q <= nbest;
          bi_q   <= nbi;
          bj_q   <= nbj;
          if (c_q == PW'(N_STOCKS - 1)) begin
            r_q <= r_q + PW'(1);
            c_q <= r_q + PW'(2);
          end else begin
            c_q <= c_q + PW'(1);
          end
          if (last_pair) begin
            i_q     <= IW'(nbi);
            j_q     <= IW'(nbj);
            max_q   <= nbest;
            lim_q   <= lim_now;
            conv_q  <= lim_now || (nbest <= thr_q);
            axiov_q <= 1'b1;
          end
        end
        OUT: if (ready_in) begin
          axiov_q <= 1'b0;
          // A converged result ends the problem; only real rotations count.
          if (!conv_q && !lim_now) cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign ready_out = (state_q == IDLE);
  assign axiov     = axiov_q;
  assign i         = i_q;
  assign j         = j_q;
  assign max_abs   = max_q;
  assign converged = conv_q;
  assign limit_hit = lim_q;
  assign mat_out   = mat_q;

endmodule

// File: tb/tb_jacobi_pivot_select.sv
// Directed bench for jacobi_pivot_select (N=4, W=16, MAX_ITER=2).
module tb_jacobi_pivot_select;

  localparam int W = 16;
  localparam int N = 4;
  localparam int IW = $clog2(W);

  logic clk = 1'b0;
  logic rst, axiiv, first, ready_out, ready_in, axiov, converged, limit_hit;
  logic [N*N*W-1:0] mat_in, mat_out;
  logic [W-1:0] threshold, max_abs;
  logic [IW-1:0] i, j;

  logic [N-1:0][N-1:0][W-1:0] m;
  int checks = 0;
  int failures = 0;
  int lat;

  jacobi_pivot_select #(.WIDTH(W), .N_STOCKS(N), .MAX_ITER(2)) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .first(first), .ready_out(ready_out),
    .mat_in(mat_in), .threshold(threshold), .ready_in(ready_in), .axiov(axiov),
    .i(i), .j(j), .max_abs(max_abs), .converged(converged),
    .limit_hit(limit_hit), .mat_out(mat_out)
  );

  always #5 clk = ~clk;

  // Diagonal 1.0 (0x0100), every off-diagonal set to off.
  task fill(input logic [W-1:0] off);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = (r == c) ? 16'h0100 : off;
  endtask

  task setp(input int r, input int c, input logic [W-1:0] v);
    m[r][c] = v;
    m[c][r] = v;
  endtask

  // Present m for one cycle; acceptance happens on the next posedge.
  task send(input logic f, input logic [W-1:0] thr);
    int n = 0;
    while (!ready_out && n < 20) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    axiiv = 1'b1; first = f; threshold = thr; mat_in = m;
    @(posedge clk); #1;
    axiiv = 1'b0; first = 1'b0;
  endtask

  // Count posedges after acceptance until axiov; bounded.
  task wait_out();
    lat = 0;
    while (!axiov && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task handshake();
    @(negedge clk); ready_in = 1'b1;
    @(posedge clk); #1; ready_in = 1'b0;
  endtask

  task test_reset();
    checks++; if (axiov !== 1'b0 || ready_out !== 1'b1) begin failures++;
      $display("FAIL reset_ctl axiov=%b ready_out=%b want 0/1", axiov, ready_out); end
    checks++; if (i !== 4'd0 || j !== 4'd1 || max_abs !== 16'h0) begin failures++;
      $display("FAIL reset_idx i=%0d j=%0d max=%h want 0/1/0", i, j, max_abs); end
    checks++; if (converged !== 1'b0 || limit_hit !== 1'b0 || mat_out !== '0) begin failures++;
      $display("FAIL reset_flags conv=%b lim=%b mat_out=%h", converged, limit_hit, mat_out); end
  endtask

  task test_pivot();
    fill(16'h0100); setp(1, 3, 16'h0500);
    send(1'b1, 16'h0010); wait_out();
    checks++; if (lat !== 6) begin failures++;
      $display("FAIL pivot_latency got=%0d want=6", lat); end
    checks++; if (i !== 4'd1 || j !== 4'd3 || max_abs !== 16'h0500 || converged !== 1'b0 || limit_hit !== 1'b0) begin
      failures++; $display("FAIL pivot got i=%0d j=%0d max=%h conv=%b lim=%b want 1 3 0500 0 0",
                          i, j, max_abs, converged, limit_hit); end
    checks++; if (mat_out !== m) begin failures++;
      $display("FAIL pivot_mat_out got=%h want=%h", mat_out, m); end
    handshake();
    checks++; if (axiov !== 1'b0 || ready_out !== 1'b1) begin failures++;
      $display("FAIL pivot_handshake axiov=%b ready_out=%b want 0/1", axiov, ready_out); end
  endtask

  task test_negative();
    fill(16'h0400); setp(0, 2, 16'hF800);
    send(1'b1, 16'h0010); wait_out();
    checks++; if (lat !== 6 || i !== 4'd0 || j !== 4'd2 || max_abs !== 16'h0800) begin failures++;
      $display("FAIL negative got lat=%0d i=%0d j=%0d max=%h want 6 0 2 0800", lat, i, j, max_abs); end
    handshake();
  endtask

  task test_saturation_ties();
    fill(16'h0100); setp(2, 3, 16'h8000);
    send(1'b1, 16'h0010); wait_out();
    checks++; if (i !== 4'd2 || j !== 4'd3 || max_abs !== 16'h7FFF || converged !== 1'b0) begin failures++;
      $display("FAIL saturation got i=%0d j=%0d max=%h conv=%b want 2 3 7fff 0", i, j, max_abs, converged); end
    handshake();
    fill(16'h0100); setp(0, 1, 16'h0300); setp(2, 3, 16'hFD00);
    send(1'b1, 16'h0010); wait_out();
    checks++; if (i !== 4'd0 || j !== 4'd1 || max_abs !== 16'h0300) begin failures++;
      $display("FAIL tie got i=%0d j=%0d max=%h want 0 1 0300", i, j, max_abs); end
    handshake();
  endtask

  task test_threshold();
    fill(16'h0008);
    send(1'b1, 16'h0008); wait_out();
    checks++; if (converged !== 1'b1 || limit_hit !== 1'b0 || max_abs !== 16'h0008 || i !== 4'd0 || j !== 4'd1) begin
      failures++; $display("FAIL thr_eq got conv=%b lim=%b max=%h i=%0d j=%0d want 1 0 0008 0 1",
                          converged, limit_hit, max_abs, i, j); end
    handshake();
    send(1'b1, 16'h0007); wait_out();
    checks++; if (converged !== 1'b0 || limit_hit !== 1'b0) begin failures++;
      $display("FAIL thr_below got conv=%b lim=%b want 0 0", converged, limit_hit); end
    handshake();
    fill(16'h0000);
    send(1'b1, 16'h0000); wait_out();
    checks++; if (i !== 4'd0 || j !== 4'd1 || max_abs !== 16'h0 || converged !== 1'b1) begin failures++;
      $display("FAIL all_zero got i=%0d j=%0d max=%h conv=%b want 0 1 0 1", i, j, max_abs, converged); end
    handshake();
  endtask

  task test_hold();
    fill(16'h0100); setp(0, 3, 16'h0600);
    send(1'b1, 16'h0010); wait_out();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (axiov !== 1'b1 || ready_out !== 1'b0 || i !== 4'd0 || j !== 4'd3 || max_abs !== 16'h0600) begin
        failures++; $display("FAIL hold cyc=%0d axiov=%b rdy=%b i=%0d j=%0d max=%h want 1 0 0 3 0600",
                            k, axiov, ready_out, i, j, max_abs); end
    end
    handshake();
  endtask

  task test_back_to_back_limit();
    fill(16'h0100); setp(1, 2, 16'h0200);
    send(1'b1, 16'h0010); wait_out();
    checks++; if (limit_hit !== 1'b0 || converged !== 1'b0) begin failures++;
      $display("FAIL limit_run1 lim=%b conv=%b want 0 0", limit_hit, converged); end
    handshake();
    send(1'b0, 16'h0010); wait_out();
    checks++; if (limit_hit !== 1'b0 || converged !== 1'b0) begin failures++;
      $display("FAIL limit_run2 lim=%b conv=%b want 0 0", limit_hit, converged); end
    handshake();
    send(1'b0, 16'h0010); wait_out();
    checks++; if (limit_hit !== 1'b1 || converged !== 1'b1 || max_abs !== 16'h0200) begin failures++;
      $display("FAIL limit_run3 lim=%b conv=%b max=%h want 1 1 0200", limit_hit, converged, max_abs); end
    handshake();
  endtask

  task test_reset_midscan();
    int seen;
    fill(16'h0100); setp(1, 2, 16'h0200);
    send(1'b1, 16'h0010); wait_out(); handshake();   // count = 1
    send(1'b0, 16'h0010);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (axiov !== 1'b0 || ready_out !== 1'b1 || mat_out !== '0) begin failures++;
      $display("FAIL rst_mid axiov=%b rdy=%b mat_out=%h want 0 1 0", axiov, ready_out, mat_out); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (axiov) seen++; end
    checks++; if (seen !== 0 || ready_out !== 1'b1) begin failures++;
      $display("FAIL rst_no_output seen=%0d rdy=%b want 0 1", seen, ready_out); end
    // Count restarted at 0: two non-converged outputs stay below the limit.
    fill(16'h0100); setp(0, 2, 16'h0700);
    send(1'b0, 16'h0010); wait_out();
    checks++; if (lat !== 6 || i !== 4'd0 || j !== 4'd2 || max_abs !== 16'h0700 || limit_hit !== 1'b0) begin
      failures++; $display("FAIL rst_after1 lat=%0d i=%0d j=%0d max=%h lim=%b want 6 0 2 0700 0",
                          lat, i, j, max_abs, limit_hit); end
    handshake();
    send(1'b0, 16'h0010); wait_out();
    checks++; if (limit_hit !== 1'b0 || converged !== 1'b0) begin failures++;
      $display("FAIL rst_after2 lim=%b conv=%b want 0 0", limit_hit, converged); end
    handshake();
  endtask

  initial begin
    rst = 1'b1; axiiv = 1'b0; first = 1'b0; ready_in = 1'b0;
    mat_in = '0; threshold = '0; m = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst = 1'b0;
    test_pivot();
    test_negative();
    test_saturation_ties();
    test_threshold();
    test_hold();
    test_back_to_back_limit();
    test_reset_midscan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
